// File: rtl/bitmem_pkg.sv
// -----------------------------------------------------------------------------
// bitmem_pkg
// Shared definitions for the UART-driven bit-memory controller: command byte
// values, the response byte for unknown commands, the controller state enum
// and the default bit-address width.
// -----------------------------------------------------------------------------
package bitmem_pkg;

   localparam int ADDR_W_DEFAULT = 16;

   localparam logic [7:0] CMD_W0     = 8'h30;  // '0' : write a 0 bit
   localparam logic [7:0] CMD_W1     = 8'h31;  // '1' : write a 1 bit
   localparam logic [7:0] CMD_RD     = 8'h52;  // 'R' : read one bit
   localparam logic [7:0] CMD_ADDR   = 8'h41;  // 'A' : load address (hi, lo)
   localparam logic [7:0] CMD_DUMP   = 8'h44;  // 'D' : dump N+1 bits
   localparam logic [7:0] RSP_ERR    = 8'h3F;  // '?' : unknown command
   localparam logic [7:0] ASCII_ZERO = 8'h30;  // read bits are sent as '0'/'1'

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR_HI,
      ST_ADDR_LO,
      ST_DUMP_LEN,
      ST_WR,
      ST_RD_ISSUE,
      ST_RD_WAIT,
      ST_TX
   } state_e;

endpackage

// File: rtl/bitmem_uart_ctrl.sv
// -----------------------------------------------------------------------------
// bitmem_uart_ctrl
// Parses command bytes from a UART receiver, sequences write/read cycles on a
// single-port 1-bit-wide memory and returns ASCII read results to a UART
// transmitter. Sole master of the memory port.
//
// Ports
//   clk, resetn            clock, synchronous active-low reset
//   rx_data, rx_valid      received byte and its one-cycle strobe
//   tx_data, tx_we         byte to transmit and its request (held until taken)
//   tx_wait                transmitter busy; transfer when tx_we && !tx_wait
//   mem_addr               bit address (the internal address register)
//   mem_we, mem_wdata      one-cycle write strobe and write bit
//   mem_re, mem_rdata      one-cycle read strobe; data valid the next cycle
//   busy                   high in WR, RD_ISSUE, RD_WAIT and TX
//   drop                   sticky: a byte arrived while busy and was discarded
// -----------------------------------------------------------------------------
module bitmem_uart_ctrl
   import bitmem_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEFAULT
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic [7:0]        tx_data,
   output logic              tx_we,
   input  logic              tx_wait,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic              mem_wdata,
   output logic              mem_re,
   input  logic              mem_rdata,
   output logic              busy,
   output logic              drop
);

   state_e            state_q,     state_d;
   logic [ADDR_W-1:0] addr_q,      addr_d;
   logic [7:0]        remain_q,    remain_d;
   logic [7:0]        hi_q,        hi_d;
   logic [7:0]        tx_data_q,   tx_data_d;
   logic              tx_we_q,     tx_we_d;
   logic              mem_we_q,    mem_we_d;
   logic              mem_wdata_q, mem_wdata_d;
   logic              mem_re_q,    mem_re_d;
   logic              busy_q,      busy_d;
   logic              drop_q,      drop_d;
   // Set for 'R' and 'D' so that TX knows to advance addr and possibly loop
   // back for the next dump bit; clear for the '?' response.
   logic              is_read_q,   is_read_d;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remain_d    = remain_q;
      hi_d        = hi_q;
      tx_data_d   = tx_data_q;
      tx_we_d     = tx_we_q;
      mem_we_d    = 1'b0;
      mem_wdata_d = mem_wdata_q;
      mem_re_d    = 1'b0;
      is_read_d   = is_read_q;
      // Bytes arriving while an operation is in flight are lost, not queued.
      drop_d      = drop_q | (rx_valid & busy_q);

      case (state_q)
         ST_IDLE: begin
            if (rx_valid) begin
               case (rx_data)
                  CMD_W0, CMD_W1: begin
                     state_d     = ST_WR;
                     mem_we_d    = 1'b1;
                     mem_wdata_d = rx_data[0];
                  end
                  CMD_RD: begin
                     state_d   = ST_RD_ISSUE;
                     mem_re_d  = 1'b1;
                     remain_d  = 8'd0;
                     is_read_d = 1'b1;
                  end
                  CMD_ADDR: state_d = ST_ADDR_HI;
                  CMD_DUMP: state_d = ST_DUMP_LEN;
                  default: begin
                     state_d   = ST_TX;
                     tx_data_d = RSP_ERR;
                     tx_we_d   = 1'b1;
                     is_read_d = 1'b0;
                  end
               endcase
            end
         end
         ST_ADDR_HI: begin
            if (rx_valid) begin
               hi_d    = rx_data;
               state_d = ST_ADDR_LO;
            end
         end
         ST_ADDR_LO: begin
            if (rx_valid) begin
               addr_d  = ADDR_W'({hi_q, rx_data});
               state_d = ST_IDLE;
            end
         end
         ST_DUMP_LEN: begin
            if (rx_valid) begin
               remain_d  = rx_data;
               is_read_d = 1'b1;
               mem_re_d  = 1'b1;
               state_d   = ST_RD_ISSUE;
            end
         end
         ST_WR: begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = ST_IDLE;
         end
         ST_RD_ISSUE: state_d = ST_RD_WAIT;
         ST_RD_WAIT: begin
            tx_data_d = ASCII_ZERO | {7'b0, mem_rdata};
            tx_we_d   = 1'b1;
            state_d   = ST_TX;
         end
         ST_TX: begin
            if (!tx_wait) begin
               tx_we_d = 1'b0;
               if (is_read_q) begin
                  addr_d = addr_q + ADDR_W'(1);
               end
               if (is_read_q && (remain_q != 8'd0)) begin
                  remain_d = remain_q - 8'd1;
                  mem_re_d = 1'b1;
                  state_d  = ST_RD_ISSUE;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d == ST_WR) || (state_d == ST_RD_ISSUE) ||
               (state_d == ST_RD_WAIT) || (state_d == ST_TX);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         remain_q    <= 8'd0;
         tx_data_q   <= 8'd0;
         tx_we_q     <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_wdata_q <= 1'b0;
         mem_re_q    <= 1'b0;
         busy_q      <= 1'b0;
         drop_q      <= 1'b0;
         is_read_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remain_q    <= remain_d;
         tx_data_q   <= tx_data_d;
         tx_we_q     <= tx_we_d;
         mem_we_q    <= mem_we_d;
         mem_wdata_q <= mem_wdata_d;
         mem_re_q    <= mem_re_d;
         busy_q      <= busy_d;
         drop_q      <= drop_d;
         is_read_q   <= is_read_d;
      end
   end

   // Address-high holding byte is only consumed after being loaded.
   always_ff @(posedge clk) begin
      hi_q <= hi_d;
   end

   assign tx_data   = tx_data_q;
   assign tx_we     = tx_we_q;
   assign mem_addr  = addr_q;
   assign mem_we    = mem_we_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_re    = mem_re_q;
   assign busy      = busy_q;
   assign drop      = drop_q;

endmodule

// File: tb/tb_bitmem_uart_ctrl.sv
module tb_bitmem_uart_ctrl;
   import bitmem_pkg::*;

   localparam int AW = 16;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic [7:0]    rx_data = 8'd0;
   logic          rx_valid = 1'b0;
   logic [7:0]    tx_data;
   logic          tx_we;
   logic          tx_wait = 1'b0;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic          mem_wdata;
   logic          mem_re;
   logic          mem_rdata = 1'b0;
   logic          busy;
   logic          drop;

   bitmem_uart_ctrl #(.ADDR_W(AW)) dut (
      .clk(clk), .resetn(resetn),
      .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_we(tx_we), .tx_wait(tx_wait),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_re(mem_re), .mem_rdata(mem_rdata),
      .busy(busy), .drop(drop)
   );

   always #5 clk = ~clk;

   // External 64K x 1 memory, cleared at start, registered read.
   logic bmem [0:(1<<AW)-1] = '{default: 1'b0};
   always @(posedge clk) begin
      if (mem_we) bmem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= bmem[mem_addr];
   end

   // Reference model state.
   logic          ref_mem [0:(1<<AW)-1] = '{default: 1'b0};
   logic [AW-1:0] ref_addr = '0;
   logic [7:0]    sb [$];

   int   n_vec = 0;
   int   n_miss = 0;
   int   n_xfer = 0;
   bit   mon_en = 1'b0;
   logic prev_we = 1'b0;
   logic prev_xfer = 1'b0;
   logic [7:0] prev_data = 8'd0;
   logic [7:0] exp_b;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Output monitor on the inactive edge: handshake rules and scoreboard pop.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("we_re_excl", 32'(mem_we & mem_re), 32'd0);
         if (prev_we && !prev_xfer)
            chk("tx_hold", 32'({tx_we, tx_data}), 32'({1'b1, prev_data}));
         if (prev_xfer)
            chk("tx_low_after_xfer", 32'(tx_we), 32'd0);
         if (tx_we && !tx_wait) begin
            n_xfer++;
            if (sb.size() == 0) begin
               chk("tx_unexpected", 32'(tx_data), 32'hFFFF_FFFF);
            end else begin
               exp_b = sb.pop_front();
               chk("tx_byte", 32'(tx_data), 32'(exp_b));
            end
         end
      end
      prev_we   = tx_we;
      prev_xfer = tx_we && !tx_wait;
      prev_data = tx_data;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      int n = 0;
      while (busy && n < 3000) begin
         tick();
         n++;
      end
      if (n >= 3000) chk("send_timeout", 32'd1, 32'd0);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy || tx_we || sb.size() != 0) && n < 3000) begin
         tick();
         n++;
      end
      chk("idle_timeout", 32'(n < 3000), 32'd1);
      tick();
   endtask

   task automatic cmd_addr(input logic [7:0] hi, input logic [7:0] lo);
      send(CMD_ADDR);
      send(hi);
      send(lo);
      ref_addr = {hi, lo};
      chk("addr_load", 32'(mem_addr), 32'(ref_addr));
   endtask

   task automatic cmd_write(input logic b);
      send(b ? CMD_W1 : CMD_W0);
      chk("wr_we", 32'(mem_we), 32'd1);
      chk("wr_addr", 32'(mem_addr), 32'(ref_addr));
      chk("wr_data", 32'(mem_wdata), 32'(b));
      ref_mem[ref_addr] = b;
      ref_addr = ref_addr + 1'b1;
   endtask

   task automatic cmd_read();
      sb.push_back(8'h30 | {7'b0, ref_mem[ref_addr]});
      send(CMD_RD);
      chk("rd_re", 32'(mem_re), 32'd1);
      chk("rd_addr", 32'(mem_addr), 32'(ref_addr));
      ref_addr = ref_addr + 1'b1;
   endtask

   task automatic cmd_dump(input logic [7:0] n);
      for (int i = 0; i <= int'(n); i++) begin
         sb.push_back(8'h30 | {7'b0, ref_mem[ref_addr]});
         ref_addr = ref_addr + 1'b1;
      end
      send(CMD_DUMP);
      send(n);
   endtask

   task automatic cmd_bad(input logic [7:0] b);
      sb.push_back(RSP_ERR);
      send(b);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int x0;
      resetn = 1'b0;
      repeat (3) tick();
      chk("rst_tx_we", 32'(tx_we), 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_re", 32'(mem_re), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_drop", 32'(drop), 32'd0);
      resetn = 1'b1;
      mon_en = 1'b1;
      tick();

      // Address load then single write.
      cmd_addr(8'h12, 8'h34);
      cmd_write(1'b1);
      tick();
      chk("wr_addr_inc", 32'(mem_addr), 32'h1235);
      chk("wr_busy_clr", 32'(busy), 32'd0);
      chk("wr_we_one_cycle", 32'(mem_we), 32'd0);

      // Write at top of space, read wraps to 0.
      cmd_addr(8'hFF, 8'hFF);
      cmd_write(1'b1);
      tick();
      chk("wrap_addr", 32'(mem_addr), 32'h0000);
      cmd_read();
      wait_idle();
      chk("rd_addr_inc", 32'(mem_addr), 32'h0001);
      cmd_addr(8'hFF, 8'hFF);
      cmd_read();
      wait_idle();
      chk("rd_wrap_addr", 32'(mem_addr), 32'h0000);

      // Write 1,0,1 then dump 3 bits.
      cmd_addr(8'h00, 8'h00);
      cmd_write(1'b1);
      cmd_write(1'b0);
      cmd_write(1'b1);
      cmd_addr(8'h00, 8'h00);
      cmd_dump(8'h02);
      wait_idle();
      chk("dump_end_addr", 32'(mem_addr), 32'h0003);

      // Dump across the top of the address space.
      cmd_addr(8'hFF, 8'hFE);
      cmd_dump(8'h03);
      wait_idle();
      chk("dump_wrap_addr", 32'(mem_addr), 32'h0002);

      // Argument bytes may look like commands.
      cmd_addr(8'h52, 8'h31);
      tick();
      chk("arg_any_addr", 32'(mem_addr), 32'h5231);
      chk("arg_any_busy", 32'(busy), 32'd0);

      // Transmitter stalled for 50 cycles during a read.
      tx_wait = 1'b1;
      x0 = n_xfer;
      cmd_read();
      repeat (50) tick();
      chk("stall_tx_we", 32'(tx_we), 32'd1);
      chk("stall_no_xfer", 32'(n_xfer), 32'(x0));
      tx_wait = 1'b0;
      wait_idle();
      chk("stall_one_xfer", 32'(n_xfer), 32'(x0 + 1));

      // Unknown commands.
      x0 = n_xfer;
      cmd_bad(8'h7A);
      wait_idle();
      chk("bad_one_xfer", 32'(n_xfer), 32'(x0 + 1));
      chk("bad_addr_same", 32'(mem_addr), 32'(ref_addr));
      cmd_bad(8'hFF);
      wait_idle();
      chk("bad_addr_same2", 32'(mem_addr), 32'(ref_addr));

      // Bytes strobed during a dump are dropped.
      chk("drop_before", 32'(drop), 32'd0);
      cmd_addr(8'h00, 8'h00);
      cmd_dump(8'h05);
      repeat (4) tick();
      rx_data = CMD_W0; rx_valid = 1'b1; tick(); rx_valid = 1'b0;
      repeat (3) tick();
      rx_data = CMD_RD; rx_valid = 1'b1; tick(); rx_valid = 1'b0;
      wait_idle();
      chk("drop_set", 32'(drop), 32'd1);
      chk("drop_dump_addr", 32'(mem_addr), 32'h0006);
      cmd_addr(8'h00, 8'h00);
      cmd_dump(8'h02);
      wait_idle();

      // Reset in the middle of a long dump.
      cmd_addr(8'h00, 8'h00);
      cmd_dump(8'hFF);
      repeat (40) tick();
      mon_en = 1'b0;
      resetn = 1'b0;
      tick();
      chk("mid_rst_tx_we", 32'(tx_we), 32'd0);
      chk("mid_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
      chk("mid_rst_drop", 32'(drop), 32'd0);
      chk("mid_rst_addr", 32'(mem_addr), 32'd0);
      resetn = 1'b1;
      sb.delete();
      ref_addr = '0;
      tick();
      mon_en = 1'b1;
      cmd_read();
      wait_idle();
      chk("post_rst_addr", 32'(mem_addr), 32'h0001);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/bitmem_uart_ctrl.md
# bitmem_uart_ctrl

Byte-command controller that sequences a single-port, 1-bit-wide cascaded block-RAM array (64K × 1) from the UART byte streams. It parses commands from the UART receiver, issues write and read cycles to the external bit memory, and returns ASCII read results to the UART transmitter. It sits between `uart_rx`/`uart_tx` and the memory in the top level, and is the only master of the memory port.

## Interface
- `ADDR_W`, 16, bit-address width; the memory holds 2^ADDR_W bits.
- `clk`  in  1  system clock.
- `resetn`  in  1  synchronous, active-low reset.
- `rx_data`  in  8  received byte; valid only in a cycle where `rx_valid` = 1.
- `rx_valid`  in  1  one-cycle strobe from the UART receiver.
- `tx_data`  out  8  byte to transmit.
- `tx_we`  out  1  transmit request.
- `tx_wait`  in  1  transmitter busy; a byte transfers in a cycle where `tx_we` = 1 and `tx_wait` = 0.
- `mem_addr`  out  ADDR_W  memory bit address, driven from the internal address register.
- `mem_we`  out  1  write strobe, one cycle wide.
- `mem_wdata`  out  1  write bit.
- `mem_re`  out  1  read strobe; `mem_rdata` is valid in the following cycle.
- `mem_rdata`  in  1  read bit.
- `busy`  out  1  high in states WR, RD_ISSUE, RD_WAIT and TX.
- `drop`  out  1  sticky flag: a byte was discarded; cleared only by reset.

## Operation
- Commands are accepted in IDLE:
  - `0x30`/`0x31` ('0'/'1'): write bit `rx_data[0]` at `addr`, then `addr`++. No response.
  - `0x52` ('R'): read the bit at `addr` and send `0x30`/`0x31`, then `addr`++.
  - `0x41` ('A') followed by hi and lo bytes: `addr` ← {hi, lo}, truncated to ADDR_W. The argument bytes may take any value.
  - `0x44` ('D') followed by byte N: dump N+1 bits starting at `addr`, one ASCII char each. N=0 gives 1 bit; N=0xFF gives 256 bits.
  - Any other byte: send `0x3F` ('?'); `addr` is unchanged.
- States: IDLE, ADDR_HI, ADDR_LO, DUMP_LEN, WR, RD_ISSUE, RD_WAIT, TX.
  - IDLE → WR / RD_ISSUE / ADDR_HI / DUMP_LEN / TX, according to the command byte.
  - ADDR_HI → ADDR_LO → IDLE.
  - DUMP_LEN → RD_ISSUE, with `remain` ← N.
  - WR → IDLE.
  - RD_ISSUE → RD_WAIT → TX.
  - TX, on transfer: if this was a read or dump and `remain` ≠ 0, then `remain`−− and go to RD_ISSUE. Otherwise go to IDLE.
- `addr` increments modulo 2^ADDR_W: 0xFFFF + 1 = 0x0000. A dump across the top of the address space wraps.
- Argument states (ADDR_HI, ADDR_LO, DUMP_LEN) wait indefinitely; there is no timeout.
- `rx_valid` in WR, RD_ISSUE, RD_WAIT or TX: the byte is discarded and `drop` ← 1.
- Reset values: all outputs 0, `addr` = 0, `remain` = 0, state IDLE.
  - Reset mid-dump or mid-TX aborts the operation; `tx_we` is low after the reset edge.

## Timing
- Write: `rx_valid` '1' at cycle T.
  - T+1: state WR, `mem_we` = 1, `mem_wdata` = 1, `mem_addr` = A.
  - T+2: `mem_addr` = A+1, state IDLE.
- Read: 'R' at T.
  - T+1: `mem_re` = 1, `mem_addr` = A.
  - T+2: `mem_rdata` sampled; `tx_data` registered as `0x30` + bit.
  - T+3 onward: `tx_we` = 1 until the transfer cycle.
- TX handshake:
  - `tx_we` and `tx_data` are held stable from assertion through the transfer cycle.
  - `tx_we` = 0 in the cycle after the transfer.
  - `addr` increments in the transfer cycle (read/dump only), so the new value is visible in the next cycle.
- Dump: each bit costs 3 cycles plus the transmitter wait, with no idle gap. `tx_we` drops for at least 2 cycles between bytes.
- 'A' load: the new `addr` is visible in the cycle after the lo byte's strobe.
- `mem_we` and `mem_re` are never high in the same cycle. Each is at most one cycle wide per operation.

## Structure
- Package `bitmem_pkg`:
  - command byte constants `CMD_W0`, `CMD_W1`, `CMD_RD`, `CMD_ADDR`, `CMD_DUMP`, `RSP_ERR`;
  - the state enum;
  - the default ADDR_W.
- Single module; no sub-module. The FSM, address counter, dump counter and TX holding register are small enough to live together.

## Test plan
- Reset, then send 'A', 0x12, 0x34, then '1' → `mem_we` pulse with `mem_addr` = 0x1234, `mem_wdata` = 1; afterwards `addr` = 0x1235 and `busy` = 0.
- Write '1','0','1' at 0x0000, then 'A',0,0 and 'D',0x02 → transmitter receives "101"; final `addr` = 0x0003.
- 'A',0xFF,0xFF, write '1', then 'R' → the write lands at 0xFFFF; the read is at 0x0000 (wrap) and returns '0' from cleared memory.
- Hold `tx_wait` = 1 for 50 cycles during 'R' → `tx_we` and `tx_data` stay stable; exactly one transfer occurs when `tx_wait` falls.
- Send 0x7A → exactly one '?' (0x3F) is transmitted; `addr` is unchanged.
- Strobe `rx_valid` during a dump → `drop` = 1 and the dump completes unaffected. Assert reset mid-dump → `tx_we` = 0, state IDLE, `drop` = 0.
